// File: rtl/multi_cond_sequencer_if.sv
// rtl/multi_cond_sequencer_if.sv - condition/arm/clear inputs and tracker/sequencer status outputs
//
// Signals:
//   cond        [N_COND]         condition pulses, one bit per channel
//   start       [1]              arm request
//   clear       [1]              synchronous clear of tracker and sequencer
//   latched     [N_COND]         sticky record of the conditions seen
//   count       [clog2(N_COND+1)] popcount of latched
//   first_idx   [clog2(N_COND)]  index of the first condition latched
//   first_valid [1]              first_idx holds a meaningful value
//   state       [3]              sequencer state code
//   active/done/fault [1 each]   sequencer status flags
// Modports: master drives cond/start/clear; slave (the sequencer) drives the rest.

interface multi_cond_sequencer_if #(
    parameter int N_COND = 4
);
    localparam int CW = $clog2(N_COND + 1);
    localparam int IW = $clog2(N_COND);

    logic [N_COND-1:0] cond;
    logic              start;
    logic              clear;
    logic [N_COND-1:0] latched;
    logic [CW-1:0]     count;
    logic [IW-1:0]     first_idx;
    logic              first_valid;
    logic [2:0]        state;
    logic              active;
    logic              done;
    logic              fault;

    modport master (
        output cond, start, clear,
        input  latched, count, first_idx, first_valid, state, active, done, fault
    );

    modport slave (
        input  cond, start, clear,
        output latched, count, first_idx, first_valid, state, active, done, fault
    );
endinterface

// File: rtl/multi_cond_sequencer.sv
// rtl/multi_cond_sequencer.sv - sticky condition tracker feeding an arm/complete/done sequencer
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high reset
//   bus    multi_cond_sequencer_if.slave (cond/start/clear in; latched/count/
//          first_idx/first_valid/state/active/done/fault out)
// Parameters:
//   N_COND          number of condition channels (2..16)
//   TIMEOUT_CYCLES  maximum ARMED dwell in cycles (>=1), used only with SEQ_TIMEOUT_EN
// Configuration macro:
//   SEQ_TIMEOUT_EN  when defined, an ARMED dwell counter forces FAULT on timeout;
//                   when undefined, there is no counter and fault is tied low.

module multi_cond_sequencer #(
    parameter int N_COND         = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    multi_cond_sequencer_if.slave      bus
);
    localparam int CW = $clog2(N_COND + 1);
    localparam int IW = $clog2(N_COND);

    if (N_COND < 2 || N_COND > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("multi_cond_sequencer: parameter out of legal range");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_COMPLETE = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    // ---------------------------------------------------------------
    // Condition tracker
    // ---------------------------------------------------------------
    logic [N_COND-1:0] r_latched;
    logic [IW-1:0]     r_first_idx;
    logic              r_first_valid;
    logic [CW-1:0]     w_count;
    logic [IW-1:0]     w_low_idx;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N_COND; i++) begin
            w_count = w_count + CW'(r_latched[i]);
        end
    end

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_COND - 1; i >= 0; i--) begin
            if (bus.cond[i]) begin
                w_low_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latched     <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
        end else if (bus.clear) begin
            r_latched     <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            r_latched <= r_latched | bus.cond;
            // Capture only on the empty -> non-empty transition.
            if (r_latched == '0 && bus.cond != '0) begin
                r_first_idx   <= w_low_idx;
                r_first_valid <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // ARMED dwell timeout
    // ---------------------------------------------------------------
    state_t r_state;
    logic   w_timeout;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;

    // Zero outside ARMED so every entry starts from 0; counts ARMED cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (bus.clear || r_state != S_ARMED) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    state_t w_next;
    logic   r_active;
    logic   r_done;
    logic   r_fault;

    always_comb begin
        w_next = S_IDLE;
        if (!bus.clear) begin
            case (r_state)
                S_IDLE:     w_next = (bus.start && r_latched != '0) ? S_ARMED : S_IDLE;
                // Completion is checked before timeout so it wins a tie.
                S_ARMED:    w_next = (&r_latched) ? S_COMPLETE :
                                     (w_timeout   ? S_FAULT : S_ARMED);
                S_COMPLETE: w_next = S_DONE;
                S_DONE:     w_next = S_DONE;
                S_FAULT:    w_next = S_FAULT;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they stay a
    // pure decode of the state register without extra output logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_active <= (w_next == S_ARMED) || (w_next == S_COMPLETE);
            r_done   <= (w_next == S_DONE);
            r_fault  <= (w_next == S_FAULT);
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.latched     = r_latched;
    assign bus.count       = w_count;
    assign bus.first_idx   = r_first_idx;
    assign bus.first_valid = r_first_valid;
    assign bus.state       = r_state;
    assign bus.active      = r_active;
    assign bus.done        = r_done;
`ifdef SEQ_TIMEOUT_EN
    assign bus.fault       = r_fault;
`else
    assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cond_sequencer.sv
// tb/tb_multi_cond_sequencer.sv - scoreboard bench for multi_cond_sequencer

module tb_multi_cond_sequencer;
    localparam int N  = 4;
    localparam int TO = 16;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multi_cond_sequencer_if #(.N_COND(N)) bus();

    multi_cond_sequencer #(
        .N_COND         (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int latched;
        int count;
        int first_idx;
        int first_valid;
        int state;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: set of seen channels, first arrival, phase, entry stamp.
    bit [N-1:0] m_set;
    int         m_first;
    int         m_phase;
    int         m_arm_step;
    int         step_no = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int popc(input bit [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_set      = '0;
        m_first    = -1;
        m_phase    = 0;
        m_arm_step = 0;
    endtask

    task automatic model_step(input bit [N-1:0] c, input bit s, input bit clr);
        int nxt;
        int dwell;
        if (clr) begin
            model_reset();
            return;
        end
        nxt = m_phase;
        case (m_phase)
            0: if (s && m_set != 0) begin nxt = 1; m_arm_step = step_no; end
            1: begin
                dwell = step_no - m_arm_step - 1;   // ARMED cycles already elapsed
                if (m_set == {N{1'b1}})           nxt = 2;
                else if (TO_EN && dwell >= TO - 1) nxt = 4;
            end
            2: nxt = 3;
            default: nxt = m_phase;
        endcase
        if (m_set == 0 && c != 0) begin
            for (int i = N - 1; i >= 0; i--) if (c[i]) m_first = i;
        end
        m_set   = m_set | c;
        m_phase = nxt;
    endtask

    task automatic step(input bit [N-1:0] c, input bit s, input bit clr);
        exp_t e;
        @(negedge clk);
        bus.cond  = c;
        bus.start = s;
        bus.clear = clr;
        step_no++;
        model_step(c, s, clr);
        e.latched     = int'(m_set);
        e.count       = popc(m_set);
        e.first_idx   = m_first;
        e.first_valid = (m_first >= 0) ? 1 : 0;
        e.state       = m_phase;
        q.push_back(e);
    endtask

    // Wait for the edge that consumes the last step, then sample.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_latched"},     int'(bus.latched), 0);
        check({tag, "_count"},       int'(bus.count), 0);
        check({tag, "_state"},       int'(bus.state), 0);
        check({tag, "_active"},      int'(bus.active), 0);
        check({tag, "_done"},        int'(bus.done), 0);
        check({tag, "_fault"},       int'(bus.fault), 0);
        check({tag, "_first_valid"}, int'(bus.first_valid), 0);
    endtask

    // Async reset applied between edges, after the last expectation was popped.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset     = 1'b1;
        bus.cond  = '1;
        bus.start = 1'b1;
        #1;
        check_reset_state("midreset");
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    // Monitor: DUT presents a new result every edge; compare one expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("latched",     int'(bus.latched),     e.latched);
            check("count",       int'(bus.count),       e.count);
            check("first_valid", int'(bus.first_valid), e.first_valid);
            if (e.first_valid != 0) check("first_idx", int'(bus.first_idx), e.first_idx);
            check("state",  int'(bus.state),  e.state);
            check("active", int'(bus.active), (e.state == 1 || e.state == 2) ? 1 : 0);
            check("done",   int'(bus.done),   (e.state == 3) ? 1 : 0);
            check("fault",  int'(bus.fault),  (e.state == 4) ? 1 : 0);
        end
    end

    initial begin
        bit [N-1:0] rc;
        model_reset();
        bus.cond  = '1;
        bus.start = 1'b1;
        bus.clear = 1'b0;
        #3;
        check_reset_state("reset");
        #14;
        check_reset_state("reset_held");
        reset = 1'b0;

        // Ordered arrival, arm mid-way, complete on final channel.
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        settle();
        check("seq_first_idx", int'(bus.first_idx), 2);
        check("seq_count_pre", int'(bus.count), 3);
        step(4'b1000, 1'b0, 1'b0);
        repeat (4) step(4'b0000, 1'b0, 1'b0);
        settle();
        check("seq_done", int'(bus.done), 1);
        step(4'b0000, 1'b0, 1'b1);

        // Simultaneous multi-bit first arrival.
        step(4'b0110, 1'b0, 1'b0);
        settle();
        check("multi_first_idx",   int'(bus.first_idx), 1);
        check("multi_first_valid", int'(bus.first_valid), 1);
        check("multi_count",       int'(bus.count), 2);
        step(4'b0000, 1'b0, 1'b1);

        // Start with nothing latched is ignored.
        repeat (5) step(4'b0000, 1'b1, 1'b0);

        // Timeout (or indefinite ARMED without the timeout feature).
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        repeat (18) step(4'b0000, 1'b0, 1'b0);
        settle();
        check("timeout_state", int'(bus.state), TO_EN ? 4 : 1);
        step(4'b0000, 1'b0, 1'b1);
        settle();
        check("timeout_clear_state", int'(bus.state), 0);

        // Completion lands on the same cycle the timeout would fire.
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        repeat (14) step(4'b0000, 1'b0, 1'b0);
        step(4'b1110, 1'b0, 1'b0);
        repeat (3) step(4'b0000, 1'b0, 1'b0);

        // Clear beats simultaneous conditions.
        step(4'b1111, 1'b0, 1'b1);
        settle();
        check("clear_vs_cond", int'(bus.latched), 0);

        // Reset abandons an armed sequence.
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        do_reset();
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            rc = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step(rc, ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        step(4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
